// File: rtl/paddle_input_conditioner.sv
// Paddle input conditioner: synchronizes and debounces the up/down player
// buttons, then turns the debounced levels into one-clock move strobes paced
// by the video frame tick. One instance per player.
module paddle_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic frame_tick,
  output logic paddle_up,
  output logic paddle_down,
  output logic up_held,
  output logic down_held
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // The wait state is entered on the first stable sample, so the transition
  // fires when the count is about to reach DEBOUNCE_CYCLES-1. This gives
  // exactly DEBOUNCE_CYCLES stable samples between the synced edge and held.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]           raw;
  logic [1:0]           sync1_q;
  logic [1:0]           sync2_q;
  deb_state_e           state_q [2];
  deb_state_e           state_d [2];
  logic [CNT_WIDTH-1:0] cnt_q   [2];
  logic [CNT_WIDTH-1:0] cnt_d   [2];
  logic [1:0]           held_q;
  logic [1:0]           held_d;
  logic                 paddle_up_q;
  logic                 paddle_up_d;
  logic                 paddle_down_q;
  logic                 paddle_down_d;

  assign raw = {btn_down_raw, btn_up_raw};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM next state: any disagreeing sample restarts the wait.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      case (state_q[b])
        RELEASED: begin
          if (sync2_q[b]) begin
            state_d[b] = PRESS_WAIT;
            cnt_d[b]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[b]) begin
            state_d[b] = RELEASED;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            state_d[b] = PRESSED;
            cnt_d[b]   = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[b]) begin
            state_d[b] = RELEASE_WAIT;
            cnt_d[b]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[b]) begin
            state_d[b] = PRESSED;
            cnt_d[b]   = '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            state_d[b] = RELEASED;
            cnt_d[b]   = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_ONE;
          end
        end
        default: begin
          state_d[b] = RELEASED;
          cnt_d[b]   = '0;
        end
      endcase
      held_d[b] = (state_d[b] == PRESSED) || (state_d[b] == RELEASE_WAIT);
    end
  end

  // Debounce FSM state, counters and registered held levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= RELEASED;
        cnt_q[b]   <= '0;
      end
      held_q <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      held_q <= held_d;
    end
  end

  // Arbitration: both held means no motion, which also keeps strobes exclusive.
  always_comb begin
    paddle_up_d   = frame_tick & held_q[0] & ~held_q[1];
    paddle_down_d = frame_tick & held_q[1] & ~held_q[0];
  end

  // Strobe registers, one clock after frame_tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      paddle_up_q   <= 1'b0;
      paddle_down_q <= 1'b0;
    end else begin
      paddle_up_q   <= paddle_up_d;
      paddle_down_q <= paddle_down_d;
    end
  end

  assign paddle_up   = paddle_up_q;
  assign paddle_down = paddle_down_q;
  assign up_held     = held_q[0];
  assign down_held   = held_q[1];

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Testbench for paddle_input_conditioner with DEBOUNCE_CYCLES=8.
// Stimulus pushes the expected strobe pair for each frame_tick into a queue;
// a monitor pops it the cycle after the tick and also checks every cycle for
// stray strobes and for up/down both high.
module tb_paddle_input_conditioner;

  logic clock;
  logic reset_n;
  logic btn_up_raw;
  logic btn_down_raw;
  logic frame_tick;
  logic paddle_up;
  logic paddle_down;
  logic up_held;
  logic down_held;

  int total = 0;
  int bad   = 0;

  logic [1:0] sb [$];
  logic       tick_seen = 1'b0;

  paddle_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .CNT_WIDTH      (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .frame_tick  (frame_tick),
    .paddle_up   (paddle_up),
    .paddle_down (paddle_down),
    .up_held     (up_held),
    .down_held   (down_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Record whether a tick was presented at this edge.
  always @(posedge clock) tick_seen <= frame_tick;

  // Monitor: compare strobes against the scoreboard, check invariants.
  always @(negedge clock) begin
    logic [1:0] exp;
    check("up_and_down_exclusive", paddle_up & paddle_down, 1'b0);
    if (tick_seen) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 1'b1, 1'b0);
      end else begin
        exp = sb.pop_front();
        check("strobe_up", paddle_up, exp[1]);
        check("strobe_down", paddle_down, exp[0]);
      end
    end else begin
      check("stray_strobe", paddle_up | paddle_down, 1'b0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one frame_tick and record the hand-computed strobes it must produce.
  task automatic tick(input logic exp_up, input logic exp_down);
    sb.push_back({exp_up, exp_down});
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  // Held level must keep ~final_val for 9 clocks and reach final_val at clock 10.
  task automatic expect_edge(input bit is_up, input logic final_val, input string name);
    logic act;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      act = is_up ? up_held : down_held;
      check(name, act, (k == 10) ? final_val : ~final_val);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    frame_tick   = 1'b0;
    step(3);
    check("reset_up_held", up_held, 1'b0);
    check("reset_down_held", down_held, 1'b0);
    check("reset_paddle_up", paddle_up, 1'b0);
    check("reset_paddle_down", paddle_down, 1'b0);
    reset_n = 1'b1;
    step(1);
    check("post_reset_up_held", up_held, 1'b0);
    check("post_reset_paddle_up", paddle_up, 1'b0);
    step(2);

    // Clean press of up, then ticks every 20 clocks.
    btn_up_raw = 1'b1;
    expect_edge(1'b1, 1'b1, "up_press_latency");
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      step(19);
    end

    // Bouncing down button never debounces.
    for (int i = 0; i < 10; i++) begin
      btn_down_raw = ~btn_down_raw;
      for (int j = 0; j < 3; j++) begin
        @(negedge clock);
        check("bounce_down_held", down_held, 1'b0);
      end
    end
    tick(1'b1, 1'b0);
    btn_down_raw = 1'b1;
    expect_edge(1'b0, 1'b1, "down_press_latency");

    // Conflict: both held, no strobes.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      step(3);
    end
    btn_down_raw = 1'b0;
    expect_edge(1'b0, 1'b0, "down_release_latency");
    tick(1'b1, 1'b0);
    step(3);

    // Short low glitch on up is rejected.
    btn_up_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("glitch_up_held", up_held, 1'b1);
    end
    btn_up_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("glitch_up_held", up_held, 1'b1);
    end
    tick(1'b1, 1'b0);
    step(2);

    // Long low releases up, strobes stop.
    btn_up_raw = 1'b0;
    expect_edge(1'b1, 1'b0, "up_release_latency");
    tick(1'b0, 1'b0);
    step(4);

    // Tick coinciding with the edge where up_held rises gives no strobe.
    btn_up_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      check("align_up_held_low", up_held, 1'b0);
    end
    tick(1'b0, 1'b0);
    check("align_up_held_high", up_held, 1'b1);
    step(2);
    tick(1'b1, 1'b0);

    // Reset mid-operation while a strobe is high and up is held.
    tick(1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_abort_paddle_up", paddle_up, 1'b0);
    check("reset_abort_up_held", up_held, 1'b0);
    check("reset_abort_down_held", down_held, 1'b0);
    check("reset_abort_paddle_down", paddle_down, 1'b0);
    step(2);
    reset_n = 1'b1;
    expect_edge(1'b1, 1'b1, "up_press_after_reset");
    tick(1'b1, 1'b0);
    step(3);

    check("scoreboard_drained", (sb.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
